control_sequencer: RTL

- Hardwired Moore control unit that drives the DataPath control strobes, replacing hand-driven strobe sequences.
- Runs the three-step fetch, decodes the opcode in IR[31:27], then steps through the execute states for each supported instruction.
- Sits beside the DataPath. It consumes the IR contents and the CON flip-flop, and emits every bus, register-enable, memory and ALU control.

---
 rtl/control_sequencer_pkg.sv | 64 ++++++
 rtl/control_sequencer_opcode_class.sv | 35 +++
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state encoding,
// ALU codes and control-vector bit positions.
package control_sequencer_pkg;

    localparam logic [4:0] INC_CODE = 5'b11111;
    localparam logic [4:0] ADD_CODE = 5'b00011;
    localparam logic [4:0] AND_CODE = 5'b00101;
    localparam logic [4:0] OR_CODE  = 5'b00110;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } op_class_t;

    // reg_in = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn}
    localparam int RI_HI   = 8;
    localparam int RI_LO   = 7;
    localparam int RI_Z    = 6;
    localparam int RI_PC   = 5;
    localparam int RI_MDR  = 4;
    localparam int RI_MAR  = 3;
    localparam int RI_Y    = 2;
    localparam int RI_OPORT = 1;
    localparam int RI_IR   = 0;

    // bus_out = {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut}
    localparam int BO_HI    = 7;
    localparam int BO_LO    = 6;
    localparam int BO_ZHI   = 5;
    localparam int BO_ZLO   = 4;
    localparam int BO_PC    = 3;
    localparam int BO_MDR   = 2;
    localparam int BO_IPORT = 1;
    localparam int BO_C     = 0;

    // rsel = {Gra, Grb, Grc, RIn, ROut, BAOut}
    localparam int RS_GRA  = 5;
    localparam int RS_GRB  = 4;
    localparam int RS_GRC  = 3;
    localparam int RS_RIN  = 2;
    localparam int RS_ROUT = 1;
    localparam int RS_BA   = 0;

endpackage

// File: rtl/control_sequencer_opcode_class.sv
// Opcode decoder: groups opcodes into execute-sequence classes and picks the ALU code
// used by that sequence's arithmetic step.
module control_sequencer_opcode_class
    import control_sequencer_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_t  o_class,
    output logic [4:0] o_alu_code
);

    always_comb begin
        o_class    = C_ILL;
        o_alu_code = 5'b00000;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_class    = C_ALU3;
                o_alu_code = i_opcode;
            end
            OP_ADDI: begin o_class = C_IMM; o_alu_code = ADD_CODE; end
            OP_ANDI: begin o_class = C_IMM; o_alu_code = AND_CODE; end
            OP_ORI:  begin o_class = C_IMM; o_alu_code = OR_CODE;  end
            OP_LDI:  begin o_class = C_LDI; o_alu_code = ADD_CODE; end
            OP_LD:   begin o_class = C_LD;  o_alu_code = ADD_CODE; end
            OP_ST:   begin o_class = C_ST;  o_alu_code = ADD_CODE; end
            OP_BR:   begin o_class = C_BR;  o_alu_code = ADD_CODE; end
            OP_JR:   o_class = C_JR;
            OP_IN:   o_class = C_IN;
            OP_OUT:  o_class = C_OUT;
            OP_NOP:  o_class = C_NOP;
            OP_HALT: o_class = C_HALT;
            default: o_class = C_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: three-step fetch, opcode decode in T3, then the
// per-class execute sequence. Outputs decode from the state register and IR.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [8:0]  reg_in,
    output logic [7:0]  bus_out,
    output logic [5:0]  rsel,
    output logic        conin,
    output logic        memread,
    output logic        memwrite,
    output logic [4:0]  alu_code,
    output logic        run,
    output logic        illegal
);

    state_t    r_state;
    state_t    w_next;
    op_class_t w_class;
    logic [4:0] w_alu;
    logic      w_unused_ir;

    assign w_unused_ir = ^ir[26:0];

    control_sequencer_opcode_class u_opcode_class (
        .i_opcode   (ir[31:27]),
        .o_class    (w_class),
        .o_alu_code (w_alu)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= S_T0;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_T0;
        case (r_state)
            S_T0: w_next = S_T1;
            S_T1: w_next = S_T2;
            S_T2: w_next = S_T3;
            S_T3: begin
                case (w_class)
                    C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_BR: w_next = S_T4;
                    C_HALT:                                 w_next = S_HALT;
                    default:                                w_next = S_T0;
                endcase
            end
            S_T4: w_next = S_T5;
            S_T5: w_next = (w_class == C_LD || w_class == C_ST || w_class == C_BR) ? S_T6 : S_T0;
            S_T6: w_next = (w_class == C_LD || w_class == C_ST) ? S_T7 : S_T0;
            S_T7: w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_T0;
        endcase
    end

    always_comb begin
        reg_in   = '0;
        bus_out  = '0;
        rsel     = '0;
        conin    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        alu_code = 5'b00000;
        run      = 1'b1;
        illegal  = 1'b0;
        case (r_state)
            S_T0: begin
                bus_out[BO_PC] = 1'b1;
                reg_in[RI_MAR] = 1'b1;
                reg_in[RI_Z]   = 1'b1;
                alu_code       = INC_CODE;
            end
            S_T1: begin
                bus_out[BO_ZLO] = 1'b1;
                reg_in[RI_PC]   = 1'b1;
                reg_in[RI_MDR]  = 1'b1;
                memread         = 1'b1;
            end
            S_T2: begin
                bus_out[BO_MDR] = 1'b1;
                reg_in[RI_IR]   = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    C_ALU3, C_IMM: begin
                        rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; reg_in[RI_Y] = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        rsel[RS_GRB] = 1'b1; rsel[RS_BA] = 1'b1; reg_in[RI_Y] = 1'b1;
                    end
                    C_BR: begin
                        rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; conin = 1'b1;
                    end
                    C_JR: begin
                        rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; reg_in[RI_PC] = 1'b1;
                    end
                    C_IN: begin
                        bus_out[BO_IPORT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
                    end
                    C_OUT: begin
                        rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; reg_in[RI_OPORT] = 1'b1;
                    end
                    C_ILL:   illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_class)
                    C_ALU3: begin
                        rsel[RS_GRC] = 1'b1; rsel[RS_ROUT] = 1'b1;
                        reg_in[RI_Z] = 1'b1; alu_code = w_alu;
                    end
                    C_IMM, C_LDI, C_LD, C_ST: begin
                        bus_out[BO_C] = 1'b1; reg_in[RI_Z] = 1'b1; alu_code = w_alu;
                    end
                    C_BR: begin
                        bus_out[BO_PC] = 1'b1; reg_in[RI_Y] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_class)
                    C_ALU3, C_IMM, C_LDI: begin
                        bus_out[BO_ZLO] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
                    end
                    C_LD, C_ST: begin
                        bus_out[BO_ZLO] = 1'b1; reg_in[RI_MAR] = 1'b1;
                    end
                    C_BR: begin
                        bus_out[BO_C] = 1'b1; reg_in[RI_Z] = 1'b1; alu_code = w_alu;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_class)
                    C_LD: begin
                        memread = 1'b1; reg_in[RI_MDR] = 1'b1;
                    end
                    C_ST: begin
                        rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; reg_in[RI_MDR] = 1'b1;
                    end
                    // Branch taken only when the condition latched in T3 is true
                    C_BR: begin
                        bus_out[BO_ZLO] = con_ff; reg_in[RI_PC] = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_class)
                    C_LD: begin
                        bus_out[BO_MDR] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1;
                    end
                    C_ST:    memwrite = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  run = 1'b0;
            default: ;
        endcase
        // Reset gates every strobe immediately so no partial write slips out
        if (!clear) begin
            reg_in   = '0;
            bus_out  = '0;
            rsel     = '0;
            conin    = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            alu_code = 5'b00000;
            run      = 1'b1;
            illegal  = 1'b0;
        end
    end

endmodule
